bcd_updown_counter: RTL and testbench

Multi-digit BCD up/down counter with synchronous load, enable, terminal-count detection and selectable wrap or saturate behaviour. It generalises the team's single-digit direction-select next-state logic into a registered, N-digit counter. It sits in the datapath as a general event/sequence counter, driving seven-segment decoders or cascading into other counters through `Tc`.

---
 rtl/bcd_updown_counter.sv | 159 +++++++++++++++
 tb/tb_bcd_updown_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Registered N-digit BCD up/down counter. It has a synchronous parallel load
// that checks each digit, a count enable, and a direction select. At the ends
// of the range it either wraps or saturates, chosen by a parameter.
//
// Parameters
//   DIGITS : number of BCD digits (>= 1); count width is 4*DIGITS
//   WRAP   : 1 = wrap at the range ends, 0 = saturate at the range ends
//
// Ports
//   Clock  in   rising-edge clock
//   Resetn in   asynchronous active-low reset
//   En     in   count enable
//   S      in   direction, 0 = up, 1 = down
//   Load   in   synchronous load; takes priority over En
//   D      in   load value, digit i = D[4i+3:4i]
//   Q      out  current count (BCD)
//   Tc     out  terminal count, combinational; drives En of a cascaded stage
//   Wrap   out  one-cycle registered pulse following a wrap-around edge
//   Err    out  sticky flag set by a rejected (non-BCD) load
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  En,
  input  logic                  S,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tc,
  output logic                  Wrap,
  output logic                  Err
);

  localparam int             W   = 4 * DIGITS;
  localparam logic [W-1:0]   TOP = {DIGITS{4'h9}};

  logic [W-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;

  logic [W-1:0] q_inc;
  logic [W-1:0] q_dec;
  logic         d_valid;
  logic         at_top;
  logic         at_bot;

  assign at_top = (q_q == TOP);
  assign at_bot = (q_q == '0);

  // Ripple increment: a digit steps only while every lower digit rolled 9->0.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    q_inc = q_q;
    carry = 1'b1;
    dig   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          q_inc[4*i +: 4] = 4'd0;
        end else begin
          q_inc[4*i +: 4] = dig + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  // Ripple decrement: a digit steps only while every lower digit rolled 0->9.
  always_comb begin
    logic       borrow;
    logic [3:0] dig;
    q_dec  = q_q;
    borrow = 1'b1;
    dig    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          q_dec[4*i +: 4] = 4'd9;
        end else begin
          q_dec[4*i +: 4] = dig - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  // A load is accepted only if every digit is a legal BCD value.
  always_comb begin
    d_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[4*i +: 4] > 4'd9) begin
        d_valid = 1'b0;
      end
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (Load) begin
      if (d_valid) begin
        q_d   = D;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (En) begin
      if (!S) begin
        if (at_top) begin
          if (WRAP) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_inc;
        end
      end else begin
        if (at_bot) begin
          if (WRAP) begin
            q_d    = TOP;
            wrap_d = 1'b1;
          end
        end else begin
          q_d = q_dec;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Terminal count does not depend on WRAP, so a cascade behaves the same
  // either way; a load cycle never counts, so it never signals terminal.
  assign Tc   = En & ~Load & ((~S & at_top) | (S & at_bot));
  assign Q    = q_q;
  assign Wrap = wrap_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Bench for bcd_updown_counter. It instantiates two copies: u_wrap with
// WRAP=1 and u_sat with WRAP=0. A vector table gives the inputs, the Tc
// expected before the edge, and the Q/Wrap/Err expected after the edge. The
// post-edge expectations are queued as each vector is driven and then popped
// and compared once the edge has been taken. The mid-cycle asynchronous reset
// is written out by hand.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst_n;

  logic       en_w, s_w, load_w;
  logic [7:0] d_w;
  logic [7:0] q_w;
  logic       tc_w, wrap_w, err_w;

  logic       en_s, s_s, load_s;
  logic [7:0] d_s;
  logic [7:0] q_s;
  logic       tc_s, wrap_s, err_s;

  int n_checks;
  int n_fail;

  typedef struct {
    bit       sat;
    bit       load;
    bit       en;
    bit       s;
    bit [7:0] d;
    bit       exp_tc;
    bit [7:0] exp_q;
    bit       exp_wrap;
    bit       exp_err;
  } vec_t;

  typedef struct {
    bit       sat;
    bit [7:0] q;
    bit       wrap;
    bit       err;
    int       idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
    .Clock  (clk),
    .Resetn (rst_n),
    .En     (en_w),
    .S      (s_w),
    .Load   (load_w),
    .D      (d_w),
    .Q      (q_w),
    .Tc     (tc_w),
    .Wrap   (wrap_w),
    .Err    (err_w)
  );

  bcd_updown_counter #(.DIGITS(2), .WRAP(1'b0)) u_sat (
    .Clock  (clk),
    .Resetn (rst_n),
    .En     (en_s),
    .S      (s_s),
    .Load   (load_s),
    .D      (d_s),
    .Q      (q_s),
    .Tc     (tc_s),
    .Wrap   (wrap_s),
    .Err    (err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [vec %0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input bit sat, input bit load, input bit en, input bit s,
                              input bit [7:0] d, input bit tc, input bit [7:0] q,
                              input bit wrap, input bit err);
    vec_t v;
    v.sat = sat; v.load = load; v.en = en; v.s = s; v.d = d;
    v.exp_tc = tc; v.exp_q = q; v.exp_wrap = wrap; v.exp_err = err;
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t e;
    n_checks = 0;
    n_fail   = 0;
    en_w = 0; s_w = 0; load_w = 0; d_w = '0;
    en_s = 0; s_s = 0; load_s = 0; d_s = '0;

    // WRAP=1 instance, starting from reset (Q=00)
    for (int i = 1; i <= 12; i++)
      add(0, 0, 1, 0, 8'h00, 0, 8'((i / 10) * 16 + (i % 10)), 0, 0);
    add(0, 1, 0, 0, 8'h98, 0, 8'h98, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h99, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 8'h00, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 1, 1, 8'h01, 0, 8'h01, 0, 0);
    add(0, 0, 1, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 1, 1, 8'h00, 1, 8'h99, 1, 0);
    add(0, 0, 1, 1, 8'h00, 0, 8'h98, 0, 0);
    add(0, 1, 0, 0, 8'h45, 0, 8'h45, 0, 0);
    add(0, 1, 0, 0, 8'h4A, 0, 8'h45, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h46, 0, 1);
    add(0, 0, 1, 1, 8'h00, 0, 8'h45, 0, 1);
    add(0, 1, 0, 0, 8'h30, 0, 8'h30, 0, 0);
    add(0, 1, 1, 0, 8'h20, 0, 8'h20, 0, 0);
    add(0, 0, 1, 0, 8'h00, 0, 8'h21, 0, 0);
    add(0, 1, 0, 0, 8'hA0, 0, 8'h21, 0, 1);
    add(0, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    add(0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 0);
    add(0, 1, 1, 0, 8'h99, 0, 8'h99, 0, 0);
    add(0, 0, 1, 0, 8'h00, 1, 8'h00, 1, 0);
    add(0, 1, 0, 0, 8'h56, 0, 8'h56, 0, 0);
    add(0, 1, 0, 0, 8'hAA, 0, 8'h56, 0, 1);
    add(0, 0, 1, 0, 8'h00, 0, 8'h57, 0, 1);
    // WRAP=0 instance, starting from reset (Q=00)
    add(1, 1, 0, 0, 8'h99, 0, 8'h99, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 0, 1, 0, 8'h00, 1, 8'h99, 0, 0);
    add(1, 0, 1, 1, 8'h00, 0, 8'h98, 0, 0);
    add(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++)
      add(1, 0, 1, 1, 8'h00, 1, 8'h00, 0, 0);
    add(1, 0, 1, 0, 8'h00, 0, 8'h01, 0, 0);

    // Reset
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("reset_q",    -1, q_w, 8'h00);
    check("reset_wrap", -1, {7'd0, wrap_w}, 8'h00);
    check("reset_err",  -1, {7'd0, err_w}, 8'h00);
    check("reset_q_sat", -1, q_s, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      if (!vecs[k].sat) begin
        load_w = vecs[k].load; en_w = vecs[k].en; s_w = vecs[k].s; d_w = vecs[k].d;
        load_s = 0; en_s = 0;
      end else begin
        load_s = vecs[k].load; en_s = vecs[k].en; s_s = vecs[k].s; d_s = vecs[k].d;
        load_w = 0; en_w = 0;
      end
      #1;
      check("tc", k, {7'd0, (vecs[k].sat ? tc_s : tc_w)}, {7'd0, vecs[k].exp_tc});
      e.sat = vecs[k].sat; e.q = vecs[k].exp_q; e.wrap = vecs[k].exp_wrap;
      e.err = vecs[k].exp_err; e.idx = k;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check("scoreboard_empty", k, 8'd0, 8'd1);
      end else begin
        e = sb.pop_front();
        check("q",    e.idx, e.sat ? q_s : q_w, e.q);
        check("wrap", e.idx, {7'd0, (e.sat ? wrap_s : wrap_w)}, {7'd0, e.wrap});
        check("err",  e.idx, {7'd0, (e.sat ? err_s : err_w)}, {7'd0, e.err});
      end
    end

    // Mid-cycle asynchronous reset while counting at 0x57 with Err set
    @(negedge clk);
    load_s = 0; en_s = 0;
    load_w = 0; en_w = 1; s_w = 0;
    #2 rst_n = 1'b0;
    #1;
    check("async_q",    100, q_w, 8'h00);
    check("async_wrap", 100, {7'd0, wrap_w}, 8'h00);
    check("async_err",  100, {7'd0, err_w}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    en_w  = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_hold", 101, q_w, 8'h00);
    @(negedge clk);
    en_w = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_count", 102, q_w, 8'h01);
    en_w = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
